// File: rtl/mem_board_if.sv
// Tracker/board bundle for the memory-match game: deck load, turn results, board view and scores.
// The tracker side drives i_* signals, the board answers on o_*; there is no backpressure.
interface mem_board_if;
    logic        i_load_en;
    logic [3:0]  i_load_idx;
    logic [3:0]  i_load_sym;
    logic        i_start;
    logic [3:0]  i_cursor;
    logic [1:0]  i_x;
    logic        i_par;
    logic [7:0]  i_selected1;
    logic [7:0]  i_selected2;
    logic        i_select;
    logic [3:0]  o_state;
    logic        o_empty;
    logic        o_player;
    logic [15:0] o_revealed;
    logic [15:0] o_matched;
    logic [3:0]  o_score0;
    logic [3:0]  o_score1;
    logic        o_game_over;
    logic [1:0]  o_winner;

    modport slave (
        input  i_load_en, i_load_idx, i_load_sym, i_start, i_cursor, i_x, i_par,
               i_selected1, i_selected2, i_select,
        output o_state, o_empty, o_player, o_revealed, o_matched, o_score0, o_score1,
               o_game_over, o_winner
    );

    modport master (
        output i_load_en, i_load_idx, i_load_sym, i_start, i_cursor, i_x, i_par,
               i_selected1, i_selected2, i_select,
        input  o_state, o_empty, o_player, o_revealed, o_matched, o_score0, o_score1,
               o_game_over, o_winner
    );
endinterface

// File: rtl/mem_board.sv
// Memory-match board: 16-card deck, pick/match/mismatch handling, player turns, scores, outcome.
// Latency: picks and turn results land 1 cycle later; state/empty are combinational; no backpressure.
module mem_board #(
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    mem_board_if.slave bus
);
    localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SHOW, S_OVER} state_t;

    state_t      r_st, w_st_nxt;
    logic [3:0]  r_sym [16];
    logic [15:0] r_shown;
    logic [15:0] r_matched;
    logic [CW-1:0] r_cnt;
    logic        r_player;
    logic [3:0]  r_score0;
    logic [3:0]  r_score1;
    logic        r_game_over;
    logic [1:0]  r_winner;

    logic        w_new_game, w_play, w_sum8, w_to_over, w_turn, w_same;
    logic        w_match, w_mismatch, w_pick, w_hide, w_two_shown, w_empty;
    logic [3:0]  w_a, w_b;
    logic [4:0]  w_sum;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd8) ? 4'd8 : v + 4'd1;
    endfunction

    assign w_a         = bus.i_selected1[3:0];
    assign w_b         = bus.i_selected2[3:0];
    assign w_same      = (w_a == w_b);
    assign w_sum       = {1'b0, r_score0} + {1'b0, r_score1};
    assign w_two_shown = ($countones(r_shown) >= 2);
    assign w_empty     = (r_st == S_PLAY) && !r_shown[bus.i_cursor]
                         && !r_matched[bus.i_cursor] && !w_two_shown;

    // Ending the game outranks a turn result, which in turn outranks a pick.
    always_comb begin
        w_new_game = ((r_st == S_IDLE) || (r_st == S_OVER)) && bus.i_start;
        w_play     = (r_st == S_PLAY);
        w_sum8     = (w_sum >= 5'd8);
        w_to_over  = w_play && (w_sum8 || bus.i_x[1]);
        w_turn     = w_play && !w_to_over && (bus.i_x == 2'b01);
        w_match    = w_turn && bus.i_par && !w_same;
        w_mismatch = w_turn && !(bus.i_par && !w_same);
        w_pick     = w_play && !w_to_over && (bus.i_x == 2'b00) && bus.i_select && w_empty;
        w_hide     = (r_st == S_SHOW) && (r_cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_st <= S_IDLE;
        else     r_st <= w_st_nxt;
    end

    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            S_IDLE:  if (w_new_game) w_st_nxt = S_PLAY;
            S_PLAY: begin
                if (w_to_over)       w_st_nxt = S_OVER;
                else if (w_mismatch) w_st_nxt = S_SHOW;
            end
            S_SHOW:  if (w_hide) w_st_nxt = S_PLAY;
            S_OVER:  if (w_new_game) w_st_nxt = S_PLAY;
            default: w_st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_sym[i] <= 4'd0;
            r_shown     <= '0;
            r_matched   <= '0;
            r_cnt       <= '0;
            r_player    <= 1'b0;
            r_score0    <= 4'd0;
            r_score1    <= 4'd0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
        end else begin
            if ((r_st == S_IDLE) && bus.i_load_en) r_sym[bus.i_load_idx] <= bus.i_load_sym;
            if (w_new_game) begin
                r_shown     <= '0;
                r_matched   <= '0;
                r_player    <= 1'b0;
                r_score0    <= 4'd0;
                r_score1    <= 4'd0;
                r_game_over <= 1'b0;
                r_winner    <= 2'b00;
            end
            if (w_pick) r_shown[bus.i_cursor] <= 1'b1;
            if (w_match) begin
                r_matched[w_a] <= 1'b1;
                r_matched[w_b] <= 1'b1;
                r_shown[w_a]   <= 1'b0;
                r_shown[w_b]   <= 1'b0;
                if (r_player) r_score1 <= sat_inc(r_score1);
                else          r_score0 <= sat_inc(r_score0);
            end
            if (w_mismatch) r_cnt <= CW'(SHOW_CYCLES - 1);
            if (r_st == S_SHOW) begin
                if (w_hide) begin
                    r_shown  <= '0;
                    r_player <= ~r_player;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
            // Outcome comes from the scores, not from the tracker's winner/tie code.
            if (w_to_over) begin
                r_game_over <= 1'b1;
                if (r_score0 > r_score1)      r_winner <= 2'b01;
                else if (r_score1 > r_score0) r_winner <= 2'b10;
                else                          r_winner <= 2'b11;
            end
        end
    end

    assign bus.o_state     = r_sym[bus.i_cursor];
    assign bus.o_empty     = w_empty;
    assign bus.o_player    = r_player;
    assign bus.o_revealed  = r_shown | r_matched;
    assign bus.o_matched   = r_matched;
    assign bus.o_score0    = r_score0;
    assign bus.o_score1    = r_score1;
    assign bus.o_game_over = r_game_over;
    assign bus.o_winner    = r_winner;
endmodule

// File: tb/tb_mem_board.sv
// Scoreboard bench for mem_board: directed game scenarios push expected board views, a monitor compares.
// Stimulus changes 1 time unit after a rising edge; the monitor samples on falling edges.
module tb_mem_board;
    localparam int SC = 3;
    localparam int F_STATE = 0, F_EMPTY = 1, F_PLAYER = 2, F_REV = 3, F_MAT = 4,
                   F_S0 = 5, F_S1 = 6, F_GO = 7, F_WIN = 8;

    typedef struct {
        int          due;
        int          fld;
        logic [15:0] val;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    mem_board_if bus();
    mem_board #(.SHOW_CYCLES(SC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rd(input int f);
        case (f)
            F_STATE:  return 16'(bus.o_state);
            F_EMPTY:  return 16'(bus.o_empty);
            F_PLAYER: return 16'(bus.o_player);
            F_REV:    return bus.o_revealed;
            F_MAT:    return bus.o_matched;
            F_S0:     return 16'(bus.o_score0);
            F_S1:     return 16'(bus.o_score1);
            F_GO:     return 16'(bus.o_game_over);
            F_WIN:    return 16'(bus.o_winner);
            default:  return 16'hdead;
        endcase
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_now(input int f, input logic [15:0] v, input string nm);
        exp_t e;
        e.due = cyc;
        e.fld = f;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].nm, rd(sb[i].fld), sb[i].val);
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation never sampled (due %0d)", sb[i].nm, sb[i].due);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input int c);
        bus.i_cursor = 4'(c);
        bus.i_select = 1'b1;
        step();
        bus.i_select = 1'b0;
    endtask

    task automatic turn(input int a, input int b, input logic p);
        bus.i_x = 2'b01;
        bus.i_par = p;
        bus.i_selected1 = 8'(a);
        bus.i_selected2 = 8'(b);
        step();
        bus.i_x = 2'b00;
        bus.i_par = 1'b0;
    endtask

    task automatic match_pair(input int a, input int b);
        pick(a);
        pick(b);
        turn(a, b, 1'b1);
    endtask

    task automatic mismatch_wait(input int a, input int b);
        pick(a);
        pick(b);
        turn(a, b, 1'b0);
        repeat (SC) step();
    endtask

    task automatic start_game();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_load_en = 1'b0; bus.i_load_idx = 4'd0; bus.i_load_sym = 4'd0;
        bus.i_start = 1'b0;   bus.i_cursor = 4'd0;   bus.i_x = 2'b00;
        bus.i_par = 1'b0;     bus.i_selected1 = 8'd0; bus.i_selected2 = 8'd0;
        bus.i_select = 1'b0;

        step();
        exp_now(F_STATE, 16'h0, "rst_state");  exp_now(F_EMPTY, 16'h0, "rst_empty");
        exp_now(F_PLAYER, 16'h0, "rst_player"); exp_now(F_REV, 16'h0, "rst_revealed");
        exp_now(F_MAT, 16'h0, "rst_matched");  exp_now(F_S0, 16'h0, "rst_score0");
        exp_now(F_S1, 16'h0, "rst_score1");    exp_now(F_GO, 16'h0, "rst_game_over");
        exp_now(F_WIN, 16'h0, "rst_winner");
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            bus.i_load_en = 1'b1; bus.i_load_idx = 4'(i); bus.i_load_sym = 4'(i >> 1);
            step();
        end
        bus.i_load_en = 1'b0;
        bus.i_cursor = 4'd5;
        exp_now(F_STATE, 16'h2, "idle_state5"); exp_now(F_EMPTY, 16'h0, "idle_empty");
        step();
        start_game();
        exp_now(F_STATE, 16'h2, "start_state5"); exp_now(F_EMPTY, 16'h1, "start_empty");
        exp_now(F_PLAYER, 16'h0, "start_player"); exp_now(F_REV, 16'h0, "start_revealed");

        pick(4);
        exp_now(F_REV, 16'h0010, "pick4_revealed");
        pick(5);
        exp_now(F_REV, 16'h0030, "pick5_revealed"); exp_now(F_EMPTY, 16'h0, "pick5_empty");
        bus.i_cursor = 4'd6;
        exp_now(F_EMPTY, 16'h0, "two_shown_empty");
        turn(4, 5, 1'b1);
        exp_now(F_MAT, 16'h0030, "match45_matched"); exp_now(F_S0, 16'h1, "match45_score0");
        exp_now(F_PLAYER, 16'h0, "match45_player"); exp_now(F_REV, 16'h0030, "match45_revealed");
        bus.i_cursor = 4'd4;
        exp_now(F_EMPTY, 16'h0, "matched_empty");
        step();

        pick(0);
        pick(2);
        exp_now(F_REV, 16'h0035, "mis_picked");
        turn(0, 2, 1'b0);
        exp_now(F_REV, 16'h0035, "mis_show1"); exp_now(F_PLAYER, 16'h0, "mis_player_hold");
        bus.i_cursor = 4'd8;
        bus.i_select = 1'b1;
        step();
        exp_now(F_REV, 16'h0035, "mis_show2");
        step();
        exp_now(F_REV, 16'h0035, "mis_show3"); exp_now(F_EMPTY, 16'h0, "show_empty");
        step();
        bus.i_select = 1'b0;
        exp_now(F_REV, 16'h0030, "mis_hidden"); exp_now(F_PLAYER, 16'h1, "mis_player_toggle");

        pick(7);
        exp_now(F_REV, 16'h00b0, "deg_picked");
        turn(7, 7, 1'b1);
        exp_now(F_S1, 16'h0, "deg_score1"); exp_now(F_MAT, 16'h0030, "deg_matched");
        step();
        step();
        exp_now(F_REV, 16'h00b0, "deg_still_shown");
        step();
        exp_now(F_REV, 16'h0030, "deg_hidden"); exp_now(F_PLAYER, 16'h0, "deg_player_toggle");
        exp_now(F_S0, 16'h1, "deg_score0");

        match_pair(0, 1); exp_now(F_S0, 16'h2, "g1_score0_2");
        match_pair(2, 3); exp_now(F_S0, 16'h3, "g1_score0_3");
        match_pair(6, 7); exp_now(F_S0, 16'h4, "g1_score0_4");
        match_pair(8, 9); exp_now(F_S0, 16'h5, "g1_score0_5");
        mismatch_wait(10, 12);
        exp_now(F_PLAYER, 16'h1, "g1_to_p1");
        match_pair(10, 11); exp_now(F_S1, 16'h1, "g1_score1_1");
        match_pair(12, 13); exp_now(F_S1, 16'h2, "g1_score1_2");
        match_pair(14, 15); exp_now(F_S1, 16'h3, "g1_score1_3");
        exp_now(F_GO, 16'h0, "g1_over_lag"); exp_now(F_MAT, 16'hffff, "g1_all_matched");
        step();
        exp_now(F_GO, 16'h1, "g1_game_over"); exp_now(F_WIN, 16'h1, "g1_winner_p0");
        exp_now(F_EMPTY, 16'h0, "over_empty");
        bus.i_load_en = 1'b1; bus.i_load_idx = 4'd5; bus.i_load_sym = 4'hf;
        step();
        bus.i_load_en = 1'b0;
        bus.i_cursor = 4'd5;
        exp_now(F_STATE, 16'h2, "over_load_ignored");

        start_game();
        exp_now(F_S0, 16'h0, "g2_score0"); exp_now(F_S1, 16'h0, "g2_score1");
        exp_now(F_GO, 16'h0, "g2_game_over"); exp_now(F_WIN, 16'h0, "g2_winner");
        exp_now(F_REV, 16'h0, "g2_revealed"); exp_now(F_PLAYER, 16'h0, "g2_player");
        exp_now(F_EMPTY, 16'h1, "g2_empty");
        match_pair(0, 1); match_pair(2, 3); match_pair(4, 5); match_pair(6, 7);
        exp_now(F_S0, 16'h4, "g2_score0_4");
        mismatch_wait(8, 10);
        match_pair(8, 9); match_pair(10, 11); match_pair(12, 13); match_pair(14, 15);
        exp_now(F_S1, 16'h4, "g2_score1_4");
        step();
        exp_now(F_GO, 16'h1, "g2_game_over_end"); exp_now(F_WIN, 16'h3, "g2_winner_tie");

        start_game();
        match_pair(0, 1);
        bus.i_x = 2'b11;
        step();
        bus.i_x = 2'b00;
        exp_now(F_GO, 16'h1, "g3_tracker_over"); exp_now(F_WIN, 16'h1, "g3_winner_from_scores");

        start_game();
        pick(0);
        pick(2);
        turn(0, 2, 1'b0);
        step();
        bus.i_cursor = 4'd5;
        #2;
        rst = 1'b1;
        #1;
        check("arst_revealed", bus.o_revealed, 16'h0);
        check("arst_state", 16'(bus.o_state), 16'h0);
        check("arst_empty", 16'(bus.o_empty), 16'h0);
        check("arst_player", 16'(bus.o_player), 16'h0);
        check("arst_score0", 16'(bus.o_score0), 16'h0);
        step();
        rst = 1'b0;
        step();
        exp_now(F_EMPTY, 16'h0, "post_rst_idle_empty"); exp_now(F_STATE, 16'h0, "post_rst_state");

        repeat (3) step();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
